// File: rtl/cfetch_pkg.sv
// cfetch_pkg: shared types and helpers for the compressed-fetch controller.
//   - Field widths of the three instruction fields (opcode / rs-rd / funct).
//   - Field slice (unpack_fields) and reassembly (pack_fields) helpers.
//   - Capture-stage state encoding and the fill-queue entry layout.
package cfetch_pkg;

  // Bit widths of the raw instruction fields.
  localparam int F1_W = 7;   // inst[6:0]
  localparam int F2_W = 15;  // {inst[24:15], inst[11:7]}
  localparam int F3_W = 10;  // {inst[31:25], inst[14:12]}

  // Key width for the default parameter set (3 + 8 + 5).
  localparam int DEF_CW = 16;

  typedef struct packed {
    logic [F3_W-1:0] f3;
    logic [F2_W-1:0] f2;
    logic [F1_W-1:0] f1;
  } fields_t;

  // One fill-queue entry at the default key width.
  typedef struct packed {
    logic [31:0]       addr;
    logic [DEF_CW-1:0] key;
  } fill_entry_t;

  // Capture stage: a single valid bit expressed as a two-state FSM.
  typedef enum logic {
    CAP_IDLE   = 1'b0,
    CAP_LOOKUP = 1'b1
  } cap_state_e;

  function automatic fields_t unpack_fields(input logic [31:0] inst);
    fields_t f;
    f.f1 = inst[6:0];
    f.f2 = {inst[24:15], inst[11:7]};
    f.f3 = {inst[31:25], inst[14:12]};
    return f;
  endfunction

  function automatic logic [31:0] pack_fields(input fields_t f);
    return {f.f3[9:3], f.f2[14:5], f.f3[2:0], f.f2[4:0], f.f1};
  endfunction

endpackage

// File: rtl/cfetch_fill_fifo.sv
// cfetch_fill_fifo: fill queue between the encode lookup and the compressed
// cache fill port.
//   clk, reset      : clock, synchronous active-high reset (clears pointers/count)
//   push, push_addr, push_key : enqueue request (ignored when full without pop)
//   pop             : dequeue request (ignored when empty)
//   head_addr, head_key : oldest entry, combinational from the read pointer
//   empty, full     : derived from the occupancy count
//   cmp_addr, cmp_match : per-entry "valid and address equal" flags
module cfetch_fill_fifo #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [31:0]       push_addr,
  input  logic [KEY_W-1:0]  push_key,
  input  logic              pop,
  output logic [31:0]       head_addr,
  output logic [KEY_W-1:0]  head_key,
  output logic              empty,
  output logic              full,
  input  logic [31:0]       cmp_addr,
  output logic [DEPTH-1:0]  cmp_match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0]      addr_mem [DEPTH];
  logic [KEY_W-1:0] key_mem  [DEPTH];

  logic push_eff;
  logic pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_eff  = pop & ~empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign push_eff = push & (~full | pop_eff);

  assign head_addr = addr_mem[rd_ptr_q];
  assign head_key  = key_mem[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      addr_mem[wr_ptr_q] <= push_addr;
      key_mem[wr_ptr_q]  <= push_key;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic [PTR_W-1:0] offs;
      logic             live;
      assign offs          = PTR_W'(gi) - rd_ptr_q;
      assign live          = ({1'b0, offs} < count_q);
      assign cmp_match[gi] = live & (addr_mem[gi] == cmp_addr);
    end
  endgenerate

endmodule

// File: rtl/cfetch_controller.sv
// cfetch_controller: instruction-fetch controller in front of a regular
// icache and a compressed icache backed by a three-field dictionary.
//   clk, reset        : clock, synchronous active-high reset
//   comp_en           : enables compressed lookup and fill capture
//   ctr_*             : saturating event counters (icache hit, compressed hit,
//                       fill issued, fill dropped for a full queue)
//   proc_*            : core fetch port (response is combinational)
//   ic_*              : regular icache request/response
//   cc_valid/addr/ready/rdata : compressed cache lookup
//   cc_fill_*         : compressed cache fill, driven from the fill queue head
//   dict_key/dict_inst: dictionary decode (combinational)
//   dict_enc_*        : dictionary encode (combinational)
module cfetch_controller
  import cfetch_pkg::*;
#(
  parameter int F1_IDX_W   = 3,
  parameter int F2_IDX_W   = 8,
  parameter int F3_IDX_W   = 5,
  parameter int FILL_DEPTH = 4,
  parameter int CTR_W      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   comp_en,
  output logic [CTR_W-1:0]                       ctr_ic_hit,
  output logic [CTR_W-1:0]                       ctr_cc_hit,
  output logic [CTR_W-1:0]                       ctr_fill,
  output logic [CTR_W-1:0]                       ctr_drop,
  input  logic                                   proc_valid,
  input  logic [31:0]                            proc_addr,
  output logic                                   proc_ready,
  output logic [31:0]                            proc_rdata,
  output logic                                   ic_valid,
  output logic [31:0]                            ic_addr,
  input  logic                                   ic_ready,
  input  logic [31:0]                            ic_rdata,
  output logic                                   cc_valid,
  output logic [31:0]                            cc_addr,
  input  logic                                   cc_ready,
  input  logic [F1_IDX_W+F2_IDX_W+F3_IDX_W-1:0]  cc_rdata,
  output logic                                   cc_fill_valid,
  output logic [31:0]                            cc_fill_addr,
  output logic [F1_IDX_W+F2_IDX_W+F3_IDX_W-1:0]  cc_fill_key,
  input  logic                                   cc_fill_ready,
  output logic [F1_IDX_W+F2_IDX_W+F3_IDX_W-1:0]  dict_key,
  input  logic [31:0]                            dict_inst,
  output logic [31:0]                            dict_enc_inst,
  input  logic                                   dict_enc_hit,
  input  logic [F1_IDX_W+F2_IDX_W+F3_IDX_W-1:0]  dict_enc_key
);

  localparam int CW    = F1_IDX_W + F2_IDX_W + F3_IDX_W;
  localparam int N_CTR = 4;

  // Fetch fan-out and combinational response.
  logic cc_hit;
  assign cc_hit     = cc_ready & comp_en;
  assign ic_valid   = proc_valid;
  assign ic_addr    = proc_addr;
  assign cc_valid   = proc_valid & comp_en;
  assign cc_addr    = proc_addr;
  assign dict_key   = cc_rdata;
  assign proc_ready = ic_ready | cc_hit;

  always_comb begin
    proc_rdata = 32'h0;
    if (ic_ready)    proc_rdata = ic_rdata;
    else if (cc_hit) proc_rdata = dict_inst;
  end

  // Capture stage: only icache hits that missed the compressed cache are
  // candidates for compression.
  cap_state_e  cap_state_q, cap_state_d;
  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_inst_q, cap_inst_d;
  logic        cap_cond;
  logic        cap_vld;

  assign cap_cond = ic_ready & ~cc_ready & comp_en;
  assign cap_vld  = (cap_state_q == CAP_LOOKUP);

  always_comb begin
    cap_state_d = CAP_IDLE;
    cap_addr_d  = cap_addr_q;
    cap_inst_d  = cap_inst_q;
    if (cap_cond) begin
      cap_state_d = CAP_LOOKUP;
      cap_addr_d  = ic_addr;
      cap_inst_d  = ic_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state_q <= CAP_IDLE;
      cap_addr_q  <= '0;
      cap_inst_q  <= '0;
    end else begin
      cap_state_q <= cap_state_d;
      cap_addr_q  <= cap_addr_d;
      cap_inst_q  <= cap_inst_d;
    end
  end

  // Lookup stage and fill queue.
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FILL_DEPTH-1:0] dup_match;
  logic                  enc_ok;
  logic                  fill_push;
  logic                  fill_pop;
  logic                  fill_drop;

  assign dict_enc_inst = cap_vld ? cap_inst_q : 32'h0;
  // Duplicates are discarded before the full check, so they never count as drops.
  assign enc_ok        = cap_vld & dict_enc_hit & ~(|dup_match);
  assign fill_pop      = cc_fill_valid & cc_fill_ready;
  assign fill_push     = enc_ok & (~fifo_full | fill_pop);
  assign fill_drop     = enc_ok & fifo_full & ~fill_pop;
  assign cc_fill_valid = ~fifo_empty;

  cfetch_fill_fifo #(
    .DEPTH (FILL_DEPTH),
    .KEY_W (CW)
  ) u_fill_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fill_push),
    .push_addr (cap_addr_q),
    .push_key  (dict_enc_key),
    .pop       (fill_pop),
    .head_addr (cc_fill_addr),
    .head_key  (cc_fill_key),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .cmp_addr  (cap_addr_q),
    .cmp_match (dup_match)
  );

  // Saturating event counters: 0 icache hit, 1 compressed hit, 2 fill, 3 drop.
  logic [N_CTR-1:0]       ctr_ev;
  logic [N_CTR*CTR_W-1:0] ctr_all;

  assign ctr_ev = {fill_drop, fill_pop, cc_hit & ~ic_ready, ic_ready};

  genvar gi;
  generate
    for (gi = 0; gi < N_CTR; gi++) begin : g_ctr
      logic [CTR_W-1:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (ctr_ev[gi] && (cnt_q != {CTR_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      end
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
      assign ctr_all[gi*CTR_W +: CTR_W] = cnt_q;
    end
  endgenerate

  assign ctr_ic_hit = ctr_all[0*CTR_W +: CTR_W];
  assign ctr_cc_hit = ctr_all[1*CTR_W +: CTR_W];
  assign ctr_fill   = ctr_all[2*CTR_W +: CTR_W];
  assign ctr_drop   = ctr_all[3*CTR_W +: CTR_W];

endmodule

// File: tb/tb_cfetch_controller.sv
// tb_cfetch_controller: directed self-checking bench for cfetch_controller.
// Encode-side dictionary model: hit whenever enc_en is set and the presented
// instruction is nonzero; key = byte-swapped low half of the instruction.
module tb_cfetch_controller;
  import cfetch_pkg::*;

  localparam int F1 = 3;
  localparam int F2 = 8;
  localparam int F3 = 5;
  localparam int CW = F1 + F2 + F3;
  localparam int DEPTH = 4;
  localparam int CTR_W = 10;

  logic             clk;
  logic             reset;
  logic             comp_en;
  logic [CTR_W-1:0] ctr_ic_hit, ctr_cc_hit, ctr_fill, ctr_drop;
  logic             proc_valid;
  logic [31:0]      proc_addr;
  logic             proc_ready;
  logic [31:0]      proc_rdata;
  logic             ic_valid;
  logic [31:0]      ic_addr;
  logic             ic_ready;
  logic [31:0]      ic_rdata;
  logic             cc_valid;
  logic [31:0]      cc_addr;
  logic             cc_ready;
  logic [CW-1:0]    cc_rdata;
  logic             cc_fill_valid;
  logic [31:0]      cc_fill_addr;
  logic [CW-1:0]    cc_fill_key;
  logic             cc_fill_ready;
  logic [CW-1:0]    dict_key;
  logic [31:0]      dict_inst;
  logic [31:0]      dict_enc_inst;
  logic             dict_enc_hit;
  logic [CW-1:0]    dict_enc_key;
  logic             enc_en;

  int n_checks;
  int n_pass;

  assign dict_enc_key = {dict_enc_inst[7:0], dict_enc_inst[15:8]};
  assign dict_enc_hit = enc_en & (dict_enc_inst != 32'h0);

  cfetch_controller #(
    .F1_IDX_W   (F1),
    .F2_IDX_W   (F2),
    .F3_IDX_W   (F3),
    .FILL_DEPTH (DEPTH),
    .CTR_W      (CTR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .comp_en       (comp_en),
    .ctr_ic_hit    (ctr_ic_hit),
    .ctr_cc_hit    (ctr_cc_hit),
    .ctr_fill      (ctr_fill),
    .ctr_drop      (ctr_drop),
    .proc_valid    (proc_valid),
    .proc_addr     (proc_addr),
    .proc_ready    (proc_ready),
    .proc_rdata    (proc_rdata),
    .ic_valid      (ic_valid),
    .ic_addr       (ic_addr),
    .ic_ready      (ic_ready),
    .ic_rdata      (ic_rdata),
    .cc_valid      (cc_valid),
    .cc_addr       (cc_addr),
    .cc_ready      (cc_ready),
    .cc_rdata      (cc_rdata),
    .cc_fill_valid (cc_fill_valid),
    .cc_fill_addr  (cc_fill_addr),
    .cc_fill_key   (cc_fill_key),
    .cc_fill_ready (cc_fill_ready),
    .dict_key      (dict_key),
    .dict_inst     (dict_inst),
    .dict_enc_inst (dict_enc_inst),
    .dict_enc_hit  (dict_enc_hit),
    .dict_enc_key  (dict_enc_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL rst_fill_valid got=%0h exp=0", cc_fill_valid); else n_pass++;
    n_checks++; if (ctr_ic_hit !== '0) $display("FAIL rst_ctr_ic got=%0h exp=0", ctr_ic_hit); else n_pass++;
    n_checks++; if (ctr_cc_hit !== '0) $display("FAIL rst_ctr_cc got=%0h exp=0", ctr_cc_hit); else n_pass++;
    n_checks++; if (ctr_fill !== '0) $display("FAIL rst_ctr_fill got=%0h exp=0", ctr_fill); else n_pass++;
    n_checks++; if (ctr_drop !== '0) $display("FAIL rst_ctr_drop got=%0h exp=0", ctr_drop); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL rst_enc_inst got=%0h exp=0", dict_enc_inst); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_ic_hit_disabled();
    comp_en = 1'b0; proc_valid = 1'b1; proc_addr = 32'h100;
    ic_ready = 1'b1; ic_rdata = 32'h00A00093;
    #1;
    n_checks++; if (proc_ready !== 1'b1) $display("FAIL ic_proc_ready got=%0h exp=1", proc_ready); else n_pass++;
    n_checks++; if (proc_rdata !== 32'h00A00093) $display("FAIL ic_proc_rdata got=%0h exp=00a00093", proc_rdata); else n_pass++;
    n_checks++; if (ic_valid !== 1'b1 || ic_addr !== 32'h100) $display("FAIL ic_req got=%0h/%0h exp=1/100", ic_valid, ic_addr); else n_pass++;
    n_checks++; if (cc_valid !== 1'b0) $display("FAIL ic_cc_valid got=%0h exp=0", cc_valid); else n_pass++;
    tick();
    ic_ready = 1'b0; proc_valid = 1'b0;
    #1;
    n_checks++; if (ctr_ic_hit !== 10'd1) $display("FAIL ic_ctr got=%0d exp=1", ctr_ic_hit); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL ic_no_capture got=%0h exp=0", dict_enc_inst); else n_pass++;
    n_checks++; if (proc_ready !== 1'b0) $display("FAIL ic_idle_ready got=%0h exp=0", proc_ready); else n_pass++;
    tick();
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL ic_no_fill got=%0h exp=0", cc_fill_valid); else n_pass++;
    $display("test_ic_hit_disabled done addr=100");
  endtask

  task automatic test_fill_path();
    comp_en = 1'b1; enc_en = 1'b1; cc_fill_ready = 1'b0;
    proc_valid = 1'b1; proc_addr = 32'h200; ic_ready = 1'b1; ic_rdata = 32'h00003412;
    #1;
    n_checks++; if (cc_valid !== 1'b1 || cc_addr !== 32'h200) $display("FAIL fp_cc_req got=%0h/%0h exp=1/200", cc_valid, cc_addr); else n_pass++;
    tick();  // t+1
    ic_ready = 1'b0; proc_valid = 1'b0;
    #1;
    n_checks++; if (dict_enc_inst !== 32'h00003412) $display("FAIL fp_enc_inst got=%0h exp=3412", dict_enc_inst); else n_pass++;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL fp_early_fill got=%0h exp=0", cc_fill_valid); else n_pass++;
    tick();  // t+2
    n_checks++; if (cc_fill_valid !== 1'b1) $display("FAIL fp_fill_valid got=%0h exp=1", cc_fill_valid); else n_pass++;
    n_checks++; if (cc_fill_addr !== 32'h200) $display("FAIL fp_fill_addr got=%0h exp=200", cc_fill_addr); else n_pass++;
    n_checks++; if (cc_fill_key !== 16'h1234) $display("FAIL fp_fill_key got=%0h exp=1234", cc_fill_key); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL fp_enc_idle got=%0h exp=0", dict_enc_inst); else n_pass++;
    tick();
    n_checks++; if (cc_fill_valid !== 1'b1 || cc_fill_addr !== 32'h200) $display("FAIL fp_hold got=%0h/%0h exp=1/200", cc_fill_valid, cc_fill_addr); else n_pass++;
    cc_fill_ready = 1'b1;
    tick();
    cc_fill_ready = 1'b0;
    #1;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL fp_popped got=%0h exp=0", cc_fill_valid); else n_pass++;
    n_checks++; if (ctr_fill !== 10'd1) $display("FAIL fp_ctr_fill got=%0d exp=1", ctr_fill); else n_pass++;
    n_checks++; if (ctr_ic_hit !== 10'd2) $display("FAIL fp_ctr_ic got=%0d exp=2", ctr_ic_hit); else n_pass++;
    $display("test_fill_path done addr=200 key=1234");
  endtask

  task automatic test_cc_hit();
    comp_en = 1'b1; ic_ready = 1'b0; cc_ready = 1'b1;
    cc_rdata = 16'h1234; dict_inst = 32'h00A00093;
    #1;
    n_checks++; if (dict_key !== 16'h1234) $display("FAIL cc_dict_key got=%0h exp=1234", dict_key); else n_pass++;
    n_checks++; if (proc_ready !== 1'b1) $display("FAIL cc_proc_ready got=%0h exp=1", proc_ready); else n_pass++;
    n_checks++; if (proc_rdata !== 32'h00A00093) $display("FAIL cc_proc_rdata got=%0h exp=00a00093", proc_rdata); else n_pass++;
    tick();
    cc_ready = 1'b0;
    #1;
    n_checks++; if (ctr_cc_hit !== 10'd1) $display("FAIL cc_ctr got=%0d exp=1", ctr_cc_hit); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL cc_no_capture got=%0h exp=0", dict_enc_inst); else n_pass++;
    // Both caches respond: icache data wins and only the icache counter moves.
    ic_ready = 1'b1; cc_ready = 1'b1; ic_rdata = 32'h00000013; dict_inst = 32'hDEADBEEF;
    #1;
    n_checks++; if (proc_rdata !== 32'h00000013) $display("FAIL cc_priority got=%0h exp=13", proc_rdata); else n_pass++;
    tick();
    ic_ready = 1'b0; cc_ready = 1'b0;
    #1;
    n_checks++; if (ctr_cc_hit !== 10'd1 || ctr_ic_hit !== 10'd3) $display("FAIL cc_both_ctrs got=%0d/%0d exp=1/3", ctr_cc_hit, ctr_ic_hit); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL cc_both_no_capture got=%0h exp=0", dict_enc_inst); else n_pass++;
    // Compressed response ignored while disabled.
    comp_en = 1'b0; cc_ready = 1'b1;
    #1;
    n_checks++; if (proc_ready !== 1'b0 || proc_rdata !== 32'h0) $display("FAIL cc_disabled got=%0h/%0h exp=0/0", proc_ready, proc_rdata); else n_pass++;
    tick();
    cc_ready = 1'b0; comp_en = 1'b1;
    #1;
    n_checks++; if (ctr_cc_hit !== 10'd1) $display("FAIL cc_disabled_ctr got=%0d exp=1", ctr_cc_hit); else n_pass++;
    $display("test_cc_hit done key=1234");
  endtask

  task automatic test_queue_full();
    logic [31:0] exp_addr [4];
    logic [15:0] exp_key  [4];
    exp_addr = '{32'h404, 32'h408, 32'h40C, 32'h414};
    exp_key  = '{16'h02A0, 16'h03A0, 16'h04A0, 16'h06A0};
    comp_en = 1'b1; enc_en = 1'b1; cc_fill_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      proc_valid = 1'b1; proc_addr = 32'h400 + 32'(4 * i);
      ic_ready = 1'b1; ic_rdata = 32'h0000A001 + 32'(i);
      tick();
    end
    ic_ready = 1'b0; proc_valid = 1'b0;
    tick();
    n_checks++; if (ctr_drop !== 10'd1) $display("FAIL qf_ctr_drop got=%0d exp=1", ctr_drop); else n_pass++;
    n_checks++; if (cc_fill_valid !== 1'b1 || cc_fill_addr !== 32'h400 || cc_fill_key !== 16'h01A0)
      $display("FAIL qf_head got=%0h/%0h/%0h exp=1/400/1a0", cc_fill_valid, cc_fill_addr, cc_fill_key); else n_pass++;
    // Hit whose lookup meets a full queue in the same cycle as a pop.
    ic_ready = 1'b1; proc_valid = 1'b1; proc_addr = 32'h414; ic_rdata = 32'h0000A006;
    tick();
    ic_ready = 1'b0; proc_valid = 1'b0; cc_fill_ready = 1'b1;
    #1;
    n_checks++; if (cc_fill_addr !== 32'h400) $display("FAIL qf_pop0 got=%0h exp=400", cc_fill_addr); else n_pass++;
    tick();
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (cc_fill_valid !== 1'b1 || cc_fill_addr !== exp_addr[j] || cc_fill_key !== exp_key[j])
        $display("FAIL qf_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", j, cc_fill_valid, cc_fill_addr, cc_fill_key, exp_addr[j], exp_key[j]);
      else n_pass++;
      $display("qf pop %0d addr=%0h key=%0h", j, cc_fill_addr, cc_fill_key);
      tick();
    end
    cc_fill_ready = 1'b0;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL qf_empty got=%0h exp=0", cc_fill_valid); else n_pass++;
    n_checks++; if (ctr_drop !== 10'd1 || ctr_fill !== 10'd6) $display("FAIL qf_ctrs got=%0d/%0d exp=1/6", ctr_drop, ctr_fill); else n_pass++;
    n_checks++; if (ctr_ic_hit !== 10'd9) $display("FAIL qf_ctr_ic got=%0d exp=9", ctr_ic_hit); else n_pass++;
    $display("test_queue_full done");
  endtask

  task automatic test_disable();
    comp_en = 1'b1; enc_en = 1'b1; cc_fill_ready = 1'b0;
    proc_valid = 1'b1; proc_addr = 32'h500; ic_ready = 1'b1; ic_rdata = 32'h0000C001;
    tick();
    comp_en = 1'b0; proc_addr = 32'h504; ic_rdata = 32'h0000C002;
    #1;
    n_checks++; if (cc_valid !== 1'b0) $display("FAIL dis_cc_valid got=%0h exp=0", cc_valid); else n_pass++;
    n_checks++; if (dict_enc_inst !== 32'h0000C001) $display("FAIL dis_inflight got=%0h exp=c001", dict_enc_inst); else n_pass++;
    tick();
    ic_ready = 1'b0; proc_valid = 1'b0;
    #1;
    n_checks++; if (dict_enc_inst !== 32'h0) $display("FAIL dis_no_capture got=%0h exp=0", dict_enc_inst); else n_pass++;
    n_checks++; if (cc_fill_valid !== 1'b1 || cc_fill_addr !== 32'h500 || cc_fill_key !== 16'h01C0)
      $display("FAIL dis_fill got=%0h/%0h/%0h exp=1/500/1c0", cc_fill_valid, cc_fill_addr, cc_fill_key); else n_pass++;
    cc_fill_ready = 1'b1;
    tick();
    cc_fill_ready = 1'b0;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL dis_one_entry got=%0h exp=0", cc_fill_valid); else n_pass++;
    comp_en = 1'b1;
    $display("test_disable done addr=500");
  endtask

  task automatic test_duplicate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    comp_en = 1'b1; enc_en = 1'b1; cc_fill_ready = 1'b0;
    proc_valid = 1'b1; proc_addr = 32'h300; ic_rdata = 32'h0000B001;
    ic_ready = 1'b1; tick();
    ic_ready = 1'b1; tick();   // back-to-back repeat
    ic_ready = 1'b0; tick();
    tick();
    ic_ready = 1'b1; tick();   // repeat while queued
    ic_ready = 1'b0; proc_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (ctr_drop !== 10'd0) $display("FAIL dup_ctr_drop got=%0d exp=0", ctr_drop); else n_pass++;
    n_checks++; if (cc_fill_valid !== 1'b1 || cc_fill_addr !== 32'h300 || cc_fill_key !== 16'h01B0)
      $display("FAIL dup_head got=%0h/%0h/%0h exp=1/300/1b0", cc_fill_valid, cc_fill_addr, cc_fill_key); else n_pass++;
    cc_fill_ready = 1'b1;
    tick();
    cc_fill_ready = 1'b0;
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL dup_single got=%0h exp=0", cc_fill_valid); else n_pass++;
    n_checks++; if (ctr_fill !== 10'd1 || ctr_ic_hit !== 10'd3) $display("FAIL dup_ctrs got=%0d/%0d exp=1/3", ctr_fill, ctr_ic_hit); else n_pass++;
    $display("test_duplicate done addr=300");
  endtask

  task automatic test_reset_mid_fill();
    comp_en = 1'b1; enc_en = 1'b1; cc_fill_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      proc_valid = 1'b1; proc_addr = 32'h600 + 32'(4 * i);
      ic_ready = 1'b1; ic_rdata = 32'h0000D001 + 32'(i);
      tick();
    end
    ic_ready = 1'b0; proc_valid = 1'b0;
    tick();
    n_checks++; if (cc_fill_valid !== 1'b1 || cc_fill_addr !== 32'h600) $display("FAIL rmf_queued got=%0h/%0h exp=1/600", cc_fill_valid, cc_fill_addr); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL rmf_fill_valid got=%0h exp=0", cc_fill_valid); else n_pass++;
    n_checks++; if (ctr_ic_hit !== '0 || ctr_cc_hit !== '0 || ctr_fill !== '0 || ctr_drop !== '0)
      $display("FAIL rmf_ctrs got=%0d/%0d/%0d/%0d exp=0/0/0/0", ctr_ic_hit, ctr_cc_hit, ctr_fill, ctr_drop); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (cc_fill_valid !== 1'b0) $display("FAIL rmf_after got=%0h exp=0", cc_fill_valid); else n_pass++;
    $display("test_reset_mid_fill done");
  endtask

  task automatic test_saturation();
    comp_en = 1'b0; proc_valid = 1'b1; proc_addr = 32'h700; ic_ready = 1'b1; ic_rdata = 32'h13;
    repeat (1023) tick();
    n_checks++; if (ctr_ic_hit !== 10'h3FF) $display("FAIL sat_max got=%0h exp=3ff", ctr_ic_hit); else n_pass++;
    tick();
    n_checks++; if (ctr_ic_hit !== 10'h3FF) $display("FAIL sat_hold got=%0h exp=3ff", ctr_ic_hit); else n_pass++;
    tick();
    n_checks++; if (ctr_ic_hit !== 10'h3FF || ctr_cc_hit !== '0) $display("FAIL sat_hold2 got=%0h/%0h exp=3ff/0", ctr_ic_hit, ctr_cc_hit); else n_pass++;
    ic_ready = 1'b0; proc_valid = 1'b0;
    $display("test_saturation done");
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1; comp_en = 1'b0; enc_en = 1'b0;
    proc_valid = 1'b0; proc_addr = '0; ic_ready = 1'b0; ic_rdata = '0;
    cc_ready = 1'b0; cc_rdata = '0; cc_fill_ready = 1'b0; dict_inst = '0;
    test_reset();
    test_ic_hit_disabled();
    test_fill_path();
    test_cc_hit();
    test_queue_full();
    test_disable();
    test_duplicate();
    test_reset_mid_fill();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
